// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl_pkg
//  Description : Shared constants for the UART bus controller: register
//                word indices, STATUS/CTRL bit positions, FSM encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_ctrl_pkg;

    // Register word indices (addr[1:0])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_TX_IDLE      = 2;
    localparam int ST_RX_OVERRUN   = 3;
    localparam int ST_FRAME_ERR    = 4;
    localparam int ST_TX_DROP      = 5;
    localparam int ST_RX_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    // Transmit sequencer encodings
    localparam logic [1:0] TX_IDLE      = 2'd0;
    localparam logic [1:0] TX_LOAD      = 2'd1;
    localparam logic [1:0] TX_WAIT_BUSY = 2'd2;
    localparam logic [1:0] TX_WAIT_DONE = 2'd3;

    // Receive sequencer encodings
    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_ACK  = 1'b1;

endpackage : uart_ctrl_pkg
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous FIFO with show-ahead head output. A push on a
//                full FIFO is accepted only when a pop happens in the same
//                cycle; a pop on an empty FIFO is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array: written on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : uart_fifo
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl
//  Description : Bus-facing UART controller. Buffers transmit and receive
//                bytes in FIFOs, sequences the UART core handshakes and
//                exposes DATA/STATUS/CTRL registers plus a level interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        wr,
    input  logic        rd,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    input  logic        rx_error,
    output logic        rx_ack
);
    import uart_ctrl_pkg::*;

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    // Bus decode
    logic bus_wr, bus_rd, wr_data, wr_status, wr_ctrl, rd_pop;

    // FIFO interfaces
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]       tx_head;
    logic [TX_CW-1:0] unused_tx_count;
    logic             rx_push, rx_full, rx_empty;
    logic [7:0]       rx_head;
    logic [RX_CW-1:0] rx_count;

    // Sequencers and registers
    logic [1:0]  tx_state_q, tx_state_d;
    logic        tx_start;
    logic [0:0]  rx_state_q, rx_state_d;
    logic        rx_take;
    logic        tx_wr_q, rx_ack_q, irq_q;
    logic [7:0]  tx_data_q;
    logic [1:0]  ctrl_q;
    logic        ovr_q, ovr_d, frm_q, frm_d, drop_q, drop_d;
    logic        tx_idle;
    logic [31:0] status_word, rd_mux, rdata_q;
    logic        unused_wdata;

    assign unused_wdata = &{1'b0, wdata[31:8]};

    assign bus_wr    = sel & wr;
    assign bus_rd    = sel & rd;
    assign wr_data   = bus_wr && (addr == REG_DATA);
    assign wr_status = bus_wr && (addr == REG_STATUS);
    assign wr_ctrl   = bus_wr && (addr == REG_CTRL);
    assign rd_pop    = bus_rd && (addr == REG_DATA) && !rx_empty;

    // Full is judged before any same-cycle pop, so a write to a full FIFO drops
    assign tx_push = wr_data && !tx_full;
    assign tx_pop  = (tx_state_q == TX_LOAD);
    assign rx_push = rx_take && rx_avail;

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (wdata[7:0]),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (unused_tx_count)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .pop_i   (rd_pop),
        .wdata_i (rx_data),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // Transmit sequencer next-state: one LOAD cycle per byte, then track busy
    always_comb begin
        tx_state_d = tx_state_q;
        tx_start   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    tx_state_d = TX_LOAD;
                    tx_start   = 1'b1;
                end
            end
            TX_LOAD:      tx_state_d = TX_WAIT_BUSY;
            TX_WAIT_BUSY: if (tx_busy)  tx_state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) tx_state_d = TX_IDLE;
            default:      tx_state_d = TX_IDLE;
        endcase
    end

    // Receive sequencer next-state: acknowledge every byte or framing error
    always_comb begin
        rx_take    = (rx_state_q == RX_IDLE) && (rx_avail || rx_error);
        rx_state_d = rx_take ? RX_ACK : RX_IDLE;
    end

    // Sticky status: a same-cycle set beats a write-one-to-clear
    always_comb begin
        ovr_d  = (rx_push && rx_full && !rd_pop) |
                 (ovr_q  & ~(wr_status & wdata[ST_RX_OVERRUN]));
        frm_d  = (rx_take && rx_error) |
                 (frm_q  & ~(wr_status & wdata[ST_FRAME_ERR]));
        drop_d = (wr_data && tx_full) |
                 (drop_q & ~(wr_status & wdata[ST_TX_DROP]));
    end

    assign tx_idle = tx_empty && (tx_state_q == TX_IDLE) && !tx_busy;

    // Read-data multiplexer; the DATA word reports emptiness in bit 8
    always_comb begin
        status_word = '0;
        status_word[ST_RX_NONEMPTY] = !rx_empty;
        status_word[ST_TX_FULL]     = tx_full;
        status_word[ST_TX_IDLE]     = tx_idle;
        status_word[ST_RX_OVERRUN]  = ovr_q;
        status_word[ST_FRAME_ERR]   = frm_q;
        status_word[ST_TX_DROP]     = drop_q;
        status_word[ST_RX_COUNT_LSB +: 8] = {{(8-RX_CW){1'b0}}, rx_count};
        rd_mux = '0;
        case (addr)
            REG_DATA:   rd_mux = {23'b0, rx_empty, (rx_empty ? 8'h00 : rx_head)};
            REG_STATUS: rd_mux = status_word;
            REG_CTRL:   rd_mux = {30'b0, ctrl_q};
            default:    rd_mux = '0;
        endcase
    end

    // All controller state; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            tx_wr_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_ack_q   <= 1'b0;
            irq_q      <= 1'b0;
            ctrl_q     <= 2'b00;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            drop_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_wr_q    <= tx_start;
            if (tx_start) tx_data_q <= tx_head;
            rx_ack_q   <= rx_take;
            irq_q      <= (ctrl_q[CTRL_RX_IRQ_EN] & !rx_empty) |
                          (ctrl_q[CTRL_TX_IRQ_EN] & tx_idle);
            if (wr_ctrl) ctrl_q <= wdata[1:0];
            ovr_q      <= ovr_d;
            frm_q      <= frm_d;
            drop_q     <= drop_d;
            if (bus_rd) rdata_q <= rd_mux;
        end
    end

    assign rdata   = rdata_q;
    assign irq     = irq_q;
    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;
    assign rx_ack  = rx_ack_q;

endmodule : uart_ctrl
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_ctrl
//  Description : Directed self-checking bench for uart_ctrl with a small
//                behavioural UART core (fixed-length busy after each tx_wr).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel, wr, rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_avail, rx_error;
    logic        rx_ack;

    int checks   = 0;
    int failures = 0;

    logic       force_busy;
    int         busy_cnt;
    int         tx_n    = 0;
    int         ack_cyc = 0;
    logic [7:0] tx_log  [64];
    logic       busy_log[64];
    logic [31:0] rv;
    int         base;

    uart_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_error (rx_error),
        .rx_ack   (rx_ack)
    );

    always #5 clk = ~clk;

    // UART core transmitter: busy for four cycles after each strobe
    assign tx_busy = force_busy | (busy_cnt != 0);
    always @(posedge clk or posedge reset) begin
        if (reset)               busy_cnt <= 0;
        else if (tx_wr)          busy_cnt <= 4;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end

    // Monitor: log every strobe cycle and every acknowledge cycle
    always @(posedge clk) begin
        if (tx_wr) begin
            tx_log[tx_n]   <= tx_data;
            busy_log[tx_n] <= tx_busy;
            tx_n           <= tx_n + 1;
        end
        if (rx_ack) ack_cyc <= ack_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic err);
        int k;
        @(negedge clk);
        rx_data = b;
        if (err) rx_error = 1'b1; else rx_avail = 1'b1;
        k = 0;
        while (!rx_ack && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rx_ack_seen", {31'b0, rx_ack}, 32'd1);
        rx_avail = 1'b0; rx_error = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx(input int target);
        int k;
        k = 0;
        while (tx_n < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("tx_pulse_count", tx_n, target);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sel = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; wdata = '0;
        rx_data = 8'h00; rx_avail = 1'b0; rx_error = 1'b0; force_busy = 1'b0;
        #1;
        chk("reset_rdata",  rdata, 32'h0);
        chk("reset_irq",    {31'b0, irq}, 32'h0);
        chk("reset_tx_wr",  {31'b0, tx_wr}, 32'h0);
        chk("reset_rx_ack", {31'b0, rx_ack}, 32'h0);
        chk("reset_txdata", {24'b0, tx_data}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        bus_read(2'd1, rv); chk("status_after_reset", rv, 32'h0000_0004);

        // Three bytes transmitted in order, each after busy fell
        bus_write(2'd0, 32'h41);
        bus_write(2'd0, 32'h42);
        bus_write(2'd0, 32'h43);
        wait_tx(3);
        chk("tx_byte0", {24'b0, tx_log[0]}, 32'h41);
        chk("tx_byte1", {24'b0, tx_log[1]}, 32'h42);
        chk("tx_byte2", {24'b0, tx_log[2]}, 32'h43);
        chk("tx_busy_at_wr1", {31'b0, busy_log[1]}, 32'h0);
        chk("tx_busy_at_wr2", {31'b0, busy_log[2]}, 32'h0);
        chk("tx_data_hold", {24'b0, tx_data}, 32'h43);
        bus_read(2'd1, rv); chk("status_tx_idle", rv, 32'h0000_0004);

        // Fill TX FIFO with the core stalled: ninth byte dropped
        @(negedge clk); force_busy = 1'b1;
        for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h10 + i);
        bus_read(2'd1, rv); chk("status_tx_full_drop", rv, 32'h0000_0022);
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, rv); chk("status_drop_cleared", rv, 32'h0000_0002);
        @(negedge clk); force_busy = 1'b0;
        wait_tx(11);
        chk("tx_drain_first", {24'b0, tx_log[3]},  32'h10);
        chk("tx_drain_last",  {24'b0, tx_log[10]}, 32'h17);
        bus_read(2'd1, rv); chk("status_after_drain", rv, 32'h0000_0004);

        // Single received byte
        base = ack_cyc;
        rx_send(8'h55, 1'b0);
        repeat (2) @(negedge clk);
        chk("rx_ack_one_cycle", ack_cyc - base, 1);
        bus_read(2'd1, rv); chk("status_rx_one", rv, 32'h0000_0105);
        bus_read(2'd0, rv); chk("rx_read_55", rv, 32'h0000_0055);
        bus_read(2'd0, rv); chk("rx_read_empty", rv, 32'h0000_0100);

        // Overrun: nine bytes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) rx_send(8'h60 + 8'(i), 1'b0);
        bus_read(2'd1, rv); chk("status_rx_overrun", rv, 32'h0000_080D);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, rv); chk("rx_overrun_data", rv, 32'h60 + i);
        end
        bus_read(2'd0, rv); chk("rx_drained_empty", rv, 32'h0000_0100);
        bus_write(2'd1, 32'h08);
        bus_read(2'd1, rv); chk("status_ovr_cleared", rv, 32'h0000_0004);

        // Framing error, then receive interrupt
        base = ack_cyc;
        rx_send(8'h00, 1'b1);
        repeat (2) @(negedge clk);
        chk("frame_ack_one_cycle", ack_cyc - base, 1);
        bus_read(2'd1, rv); chk("status_frame_err", rv, 32'h0000_0014);
        rx_send(8'h77, 1'b0);
        bus_write(2'd2, 32'h1);
        chk("irq_not_yet", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_rx_set", {31'b0, irq}, 32'h1);
        bus_read(2'd2, rv); chk("ctrl_readback", rv, 32'h1);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, rv); chk("ctrl_readback_mask", rv, 32'h3);
        bus_read(2'd0, rv); chk("rx_read_77", rv, 32'h0000_0077);
        bus_write(2'd2, 32'h1);
        repeat (2) @(negedge clk);
        chk("irq_rx_cleared", {31'b0, irq}, 32'h0);

        // Reserved address
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rv); chk("rsvd_read_zero", rv, 32'h0);
        bus_read(2'd2, rv); chk("ctrl_after_rsvd", rv, 32'h1);
        bus_read(2'd1, rv); chk("status_after_rsvd", rv, 32'h0000_0014);
        bus_write(2'd1, 32'h10);

        // Reset in the middle of a transmission
        rx_send(8'h88, 1'b0);
        bus_read(2'd2, rv);
        bus_write(2'd0, 32'h99);
        bus_write(2'd0, 32'h9A);
        base = tx_n;
        begin
            int k;
            k = 0;
            while (tx_n == base && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        chk("pre_reset_tx_started", tx_n, base + 1);
        @(negedge clk);
        chk("pre_reset_irq", {31'b0, irq}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rdata",  rdata, 32'h0);
        chk("async_irq",    {31'b0, irq}, 32'h0);
        chk("async_tx_wr",  {31'b0, tx_wr}, 32'h0);
        chk("async_rx_ack", {31'b0, rx_ack}, 32'h0);
        chk("async_txdata", {24'b0, tx_data}, 32'h0);
        @(negedge clk); reset = 1'b0;
        base = tx_n;
        repeat (20) @(negedge clk);
        chk("no_tx_after_reset", tx_n, base);
        bus_read(2'd1, rv); chk("status_after_midreset", rv, 32'h0000_0004);
        bus_read(2'd0, rv); chk("rx_empty_after_reset", rv, 32'h0000_0100);
        chk("irq_after_reset", {31'b0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_ctrl
`default_nettype wire
